// File: rtl/ysyx_22050039_lsu_if.sv
// Bundle of the LSU's request, response and memory-side signals.
// slave is the LSU's view; master is the environment (execute stage plus memory).
interface ysyx_22050039_lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_req_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_req_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// Load/store unit: one outstanding access, byte-lane alignment of store data
// and mask, load extraction with sign/zero extension, misalignment trapping.
module ysyx_22050039_lsu #(
  parameter int XLEN = 64
) (
  input logic              clk,
  input logic              rst,
  ysyx_22050039_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            misaligned;

  logic [XLEN-1:0] addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic [1:0]      size_p0;
  logic            wen_p0;
  logic            uns_p0;

  logic [XLEN-1:0] rdata_p1;
  logic            err_p1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    return {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      2'd1:    return {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      2'd2:    return {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  assign accept     = (state == IDLE) && bus.req_valid && !rst;
  assign misaligned = is_misaligned(bus.req_size, bus.req_addr[2:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid)     state_nxt = misaligned ? RESP : REQ;
      REQ:  if (bus.mem_req_ready) state_nxt = WAIT;
      WAIT: if (bus.mem_rvalid)    state_nxt = RESP;
      RESP: if (bus.resp_ready)    state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // p0: request fields latched at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      size_p0  <= bus.req_size;
      wen_p0   <= bus.req_wen;
      uns_p0   <= bus.req_unsigned;
    end
  end

  // p1: response payload; zero for stores and for trapped accesses
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p1 <= '0;
      err_p1   <= misaligned;
    end else if (state == WAIT && bus.mem_rvalid) begin
      rdata_p1 <= wen_p0 ? '0 : load_ext(bus.mem_rdata, addr_p0[2:0], size_p0, uns_p0);
    end
  end

  // Outputs are forced low while rst is high, even before the state register clears.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = '0;
    bus.resp_err      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = 8'h00;
    if (!rst) begin
      case (state)
        IDLE: bus.req_ready = 1'b1;
        REQ: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_addr      = {addr_p0[XLEN-1:3], 3'b000};
          bus.mem_wen       = wen_p0;
          bus.mem_wdata     = wdata_p0 << {addr_p0[2:0], 3'b000};
          bus.mem_wmask     = wen_p0 ? lane_mask(size_p0, addr_p0[2:0]) : 8'h00;
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rdata_p1;
          bus.resp_err   = err_p1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Bench for ysyx_22050039_lsu: directed vector table, reset corner cases and
// randomized accesses checked against a byte-level reference model.
module tb_ysyx_22050039_lsu;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22050039_lsu_if #(.XLEN(XLEN)) bus ();
  ysyx_22050039_lsu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mrdata;
    logic        err;
    logic [63:0] maddr;
    logic [7:0]  wmask;
    logic [63:0] mwdata;
    logic [63:0] rdata;
    int          dm;
    int          dw;
    int          dr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
    chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'd0);
  endtask

  // Reference model: works byte by byte from the access size and offset.
  function automatic vec_t model(input logic wen, input logic [1:0] size, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] mrdata);
    vec_t v;
    int n;
    int off;
    n = 1 << size;
    off = int'(addr[2:0]);
    v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.err = (off % n) != 0;
    v.maddr = addr & ~64'h7;
    v.wmask = 8'h00;
    v.mwdata = 64'd0;
    v.rdata = 64'd0;
    v.dm = 0; v.dw = 0; v.dr = 0;
    for (int j = 0; j < 8; j++)
      if (j >= off) v.mwdata[8*j +: 8] = wdata[8*(j-off) +: 8];
    if (!v.err) begin
      if (wen) begin
        for (int i = 0; i < n; i++) v.wmask[off+i] = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) v.rdata[8*i +: 8] = mrdata[8*(off+i) +: 8];
        if (!uns && v.rdata[8*n-1])
          for (int k = 8*n; k < 64; k++) v.rdata[k] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    bus.req_valid = 1'b1;
    bus.req_wen = v.wen;
    bus.req_size = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    chk({tag, "_accept_ready"}, 64'(bus.req_ready), 64'd1);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_wen = 1'($urandom_range(0, 1));
    bus.req_size = 2'($urandom_range(0, 3));
    bus.req_addr = {$urandom(), $urandom()};
    bus.req_wdata = {$urandom(), $urandom()};
    if (!v.err) begin
      for (int i = 0; i <= v.dm; i++) begin
        bus.mem_req_ready = (i == v.dm);
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata = {$urandom(), $urandom()};
        @(negedge clk);
        chk({tag, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
        chk({tag, "_mem_addr"}, bus.mem_addr, v.maddr);
        chk({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'(v.wen));
        chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask), 64'(v.wmask));
        chk({tag, "_mem_wdata"}, bus.mem_wdata, v.mwdata);
        chk({tag, "_req_ready_busy"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_resp_valid_early"}, 64'(bus.resp_valid), 64'd0);
        cyc();
      end
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i <= v.dw; i++) begin
        bus.mem_rvalid = (i == v.dw);
        bus.mem_rdata = (i == v.dw) ? v.mrdata : {$urandom(), $urandom()};
        @(negedge clk);
        chk({tag, "_wait_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, "_wait_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_wait_req_ready"}, 64'(bus.req_ready), 64'd0);
        cyc();
      end
      bus.mem_rvalid = 1'b0;
    end
    for (int i = 0; i <= v.dr; i++) begin
      bus.resp_ready = (i == v.dr);
      bus.req_valid = (i == v.dr);
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata = {$urandom(), $urandom()};
      @(negedge clk);
      chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({tag, "_resp_rdata"}, bus.resp_rdata, v.rdata);
      chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'(v.err));
      chk({tag, "_resp_req_ready"}, 64'(bus.req_ready), 64'd0);
      chk({tag, "_resp_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
      cyc();
    end
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_done_req_ready"}, 64'(bus.req_ready), 64'd1);
    cyc();
  endtask

  initial begin
    //          wen size uns addr                   wdata                  mrdata                 err maddr                  wmask  mwdata                 rdata                  dm dw dr
    tbl[0]  = '{1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h0000_0000_8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_F000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_F000_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_00F0, 0, 0, 0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_BEEF, 64'h0, 1'b0, 64'h0000_0000_8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 0, 0, 0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0002, 64'h0, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0, 0, 0, 0};
    tbl[5]  = '{1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h0000_0000_8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 3, 1, 2};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 64'h0000_0000_8000_0002, 64'h0, 64'h0000_0000_8001_0000, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0};
    tbl[7]  = '{1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0004, 64'h0, 64'h89AB_CDEF_0123_4567, 1'b0, 64'h0000_0000_8000_0000, 8'h00, 64'h0, 64'h0000_0000_89AB_CDEF, 0, 0, 0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0010, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'h0000_0000_8000_0010, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 2, 0};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 1'b0, 64'h0000_0000_8000_0000, 8'h20, 64'hFFFF_5A00_0000_0000, 64'h0, 1, 0, 1};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0004, 64'h1234, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h0, 0, 0, 3};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_000C, 64'h0, 64'h7FFF_FFFF_0000_0000, 1'b0, 64'h0000_0000_8000_0008, 8'h00, 64'h0, 64'h0000_0000_7FFF_FFFF, 0, 0, 0};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'd0; bus.req_wdata = 64'd0; bus.resp_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
    cyc();
    cyc();
    @(negedge clk);
    chk_all_zero("reset");
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_req_ready", 64'(bus.req_ready), 64'd1);
    cyc();

    for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for memory; a late completion must be ignored.
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h8000_0001; bus.req_wdata = 64'd0;
    @(negedge clk);
    chk("rstmid_accept", 64'(bus.req_ready), 64'd1);
    cyc();
    bus.req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
    cyc();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rstmid_in_reset");
    cyc();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("rstmid_first_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rstmid_first_resp_valid", 64'(bus.resp_valid), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_after_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rstmid_after_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
      chk("rstmid_after_req_ready", 64'(bus.req_ready), 64'd1);
      cyc();
    end

    for (int n = 0; n < 300; n++) begin
      vec_t v;
      logic [63:0] a;
      a = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
      v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      v.dm = $urandom_range(0, 3);
      v.dw = $urandom_range(0, 3);
      v.dr = $urandom_range(0, 3);
      run_txn(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
